// File: rtl/sig_edge_wdt_checker.sv
// sig_edge_wdt_checker: multi-channel edge-direction checker with a per-channel
// microsecond watchdog. Each channel is armed with an expected edge direction
// and a timeout, then waits for the first transition of its input.
//
// Optional build macro: SIG_EDGE_WDT_GLITCH_FILTER_EN enables a stability filter
// that requires FILT_CYC consecutive non-baseline samples before a transition
// is recognised.
//
// Ports:
//   tb_clk        clock
//   tb_rst        asynchronous active-high reset
//   arm           per-channel arm pulse (restarts an armed channel)
//   exp_rise      expected direction, 1 = rising; sampled on arm
//   timeout_us    per-channel timeout in us, channel i at [i*TMR_W +: TMR_W]; 0 = no watchdog
//   sig_in        monitored signals, synchronous to tb_clk
//   abort         synchronous return of all channels to IDLE, clears all flags
//   busy          channel is ARMED
//   done          correct transition seen (sticky)
//   err_dir       transition in the wrong direction (sticky)
//   err_to        watchdog expired (sticky)
//   err_any       registered OR of all error flags
//   first_err_ch  lowest-index channel of the first error event; valid while err_any
module sig_edge_wdt_checker #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned TMR_W      = 16,
  parameter int unsigned CYC_PER_US = 100,
  parameter int unsigned FILT_CYC   = 4,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    tb_clk,
  input  logic                    tb_rst,
  input  logic [NUM_CH-1:0]       arm,
  input  logic [NUM_CH-1:0]       exp_rise,
  input  logic [NUM_CH*TMR_W-1:0] timeout_us,
  input  logic [NUM_CH-1:0]       sig_in,
  input  logic                    abort,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       err_dir,
  output logic [NUM_CH-1:0]       err_to,
  output logic                    err_any,
  output logic [CH_W-1:0]         first_err_ch
);

  localparam int unsigned CYC_W = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, PASS, FAIL} state_e;

  state_e             state_q [NUM_CH];
  logic [CYC_W-1:0]   cyc_q   [NUM_CH];
  logic [TMR_W-1:0]   us_q    [NUM_CH];
  logic [TMR_W-1:0]   to_q    [NUM_CH];
  logic [NUM_CH-1:0]  exp_q;
  logic [NUM_CH-1:0]  base_q;
  logic [NUM_CH-1:0]  busy_q;
  logic [NUM_CH-1:0]  done_q;
  logic [NUM_CH-1:0]  err_dir_q;
  logic [NUM_CH-1:0]  err_to_q;
  logic               err_any_q;
  logic [CH_W-1:0]    first_err_ch_q;

`ifdef SIG_EDGE_WDT_GLITCH_FILTER_EN
  localparam int unsigned FILT_W = (FILT_CYC > 1) ? $clog2(FILT_CYC + 1) : 1;
  logic [FILT_W-1:0]  filt_q  [NUM_CH];
`else
  localparam int unsigned filt_unused = FILT_CYC;
`endif

  logic [NUM_CH-1:0]  hit_c;
  logic [NUM_CH-1:0]  wrap_c;
  logic [NUM_CH-1:0]  expire_c;
  logic [NUM_CH-1:0]  errs_c;
  logic [CH_W-1:0]    low_err_c;
  logic               low_found_c;

  // Per-channel transition recognition and watchdog expiry.
  always_comb begin
    hit_c    = '0;
    wrap_c   = '0;
    expire_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
`ifdef SIG_EDGE_WDT_GLITCH_FILTER_EN
      hit_c[i] = (sig_in[i] != base_q[i]) && (filt_q[i] == FILT_W'(FILT_CYC - 1));
`else
      hit_c[i] = (sig_in[i] != base_q[i]);
`endif
      wrap_c[i]   = (cyc_q[i] == CYC_W'(CYC_PER_US - 1));
      // Expire on the edge where the us counter would reach the timeout.
      expire_c[i] = (to_q[i] != '0) && wrap_c[i] && ((us_q[i] + TMR_W'(1)) == to_q[i]);
    end
  end

  // Lowest-index channel currently flagging an error.
  always_comb begin
    errs_c      = err_dir_q | err_to_q;
    low_err_c   = '0;
    low_found_c = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (errs_c[i] && !low_found_c) begin
        low_err_c   = CH_W'(i);
        low_found_c = 1'b1;
      end
    end
  end

  // Channel FSMs, watchdog counters and summary flags.
  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst || abort) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        state_q[i] <= IDLE;
        cyc_q[i]   <= '0;
        us_q[i]    <= '0;
        to_q[i]    <= '0;
`ifdef SIG_EDGE_WDT_GLITCH_FILTER_EN
        filt_q[i]  <= '0;
`endif
      end
      exp_q          <= '0;
      base_q         <= '0;
      busy_q         <= '0;
      done_q         <= '0;
      err_dir_q      <= '0;
      err_to_q       <= '0;
      err_any_q      <= 1'b0;
      first_err_ch_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (arm[i]) begin
          state_q[i]   <= ARMED;
          busy_q[i]    <= 1'b1;
          exp_q[i]     <= exp_rise[i];
          base_q[i]    <= sig_in[i];
          to_q[i]      <= timeout_us[i*TMR_W +: TMR_W];
          cyc_q[i]     <= '0;
          us_q[i]      <= '0;
          done_q[i]    <= 1'b0;
          err_dir_q[i] <= 1'b0;
          err_to_q[i]  <= 1'b0;
`ifdef SIG_EDGE_WDT_GLITCH_FILTER_EN
          filt_q[i]    <= '0;
`endif
        end else if (state_q[i] == ARMED) begin
          if (hit_c[i]) begin
            // The new level is the inverse of the baseline.
            busy_q[i] <= 1'b0;
            if (sig_in[i] == exp_q[i]) begin
              state_q[i] <= PASS;
              done_q[i]  <= 1'b1;
            end else begin
              state_q[i]   <= FAIL;
              err_dir_q[i] <= 1'b1;
            end
          end else if (expire_c[i]) begin
            state_q[i]  <= FAIL;
            busy_q[i]   <= 1'b0;
            err_to_q[i] <= 1'b1;
          end else begin
            // A zero timeout freezes the watchdog.
            if (to_q[i] != '0) begin
              if (wrap_c[i]) begin
                cyc_q[i] <= '0;
                us_q[i]  <= us_q[i] + TMR_W'(1);
              end else begin
                cyc_q[i] <= cyc_q[i] + CYC_W'(1);
              end
            end
`ifdef SIG_EDGE_WDT_GLITCH_FILTER_EN
            if (sig_in[i] != base_q[i]) begin
              filt_q[i] <= filt_q[i] + FILT_W'(1);
            end else begin
              filt_q[i] <= '0;
            end
`endif
          end
        end
      end
      err_any_q <= |errs_c;
      // First-error channel is captured only on the rising edge of err_any.
      if (!err_any_q && (|errs_c)) begin
        first_err_ch_q <= low_err_c;
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err_dir      = err_dir_q;
  assign err_to       = err_to_q;
  assign err_any      = err_any_q;
  assign first_err_ch = first_err_ch_q;

endmodule

// File: tb/tb_sig_edge_wdt_checker.sv
// Self-checking bench for sig_edge_wdt_checker (default build, no glitch filter).
module tb_sig_edge_wdt_checker;

  localparam int NCH = 8;
  localparam int TW  = 16;
  localparam int CPU = 100;

  logic              tb_clk = 1'b0;
  logic              tb_rst;
  logic [NCH-1:0]    arm;
  logic [NCH-1:0]    exp_rise;
  logic [NCH*TW-1:0] timeout_us;
  logic [NCH-1:0]    sig_in;
  logic              abort;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done;
  logic [NCH-1:0]    err_dir;
  logic [NCH-1:0]    err_to;
  logic              err_any;
  logic [2:0]        first_err_ch;

  int checks = 0;
  int errors = 0;

  sig_edge_wdt_checker #(
    .NUM_CH(NCH), .TMR_W(TW), .CYC_PER_US(CPU), .FILT_CYC(4)
  ) dut (
    .tb_clk(tb_clk), .tb_rst(tb_rst), .arm(arm), .exp_rise(exp_rise),
    .timeout_us(timeout_us), .sig_in(sig_in), .abort(abort),
    .busy(busy), .done(done), .err_dir(err_dir), .err_to(err_to),
    .err_any(err_any), .first_err_ch(first_err_ch)
  );

  always #5 tb_clk = ~tb_clk;

  initial begin
    #3000000;
    $display("FAIL sim_time_limit: run did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Arms the masked channels with one timeout; returns just after the arm edge.
  task automatic do_arm(input logic [NCH-1:0] m, input logic [NCH-1:0] er, input int t);
    arm = m;
    for (int i = 0; i < NCH; i++) begin
      if (m[i]) begin
        exp_rise[i] = er[i];
        timeout_us[i*TW +: TW] = TW'(t);
      end
    end
    tick();
    arm = '0;
  endtask

  task automatic test_reset();
    tb_rst = 1'b1; arm = '0; exp_rise = '0; timeout_us = '0; sig_in = '0; abort = 1'b0;
    ticks(3);
    tb_rst = 1'b0;
    tick();
    checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy got %h exp 00", busy); end
    checks++; if (done !== '0) begin errors++; $display("FAIL reset_done got %h exp 00", done); end
    checks++; if ({err_dir, err_to} !== '0) begin errors++; $display("FAIL reset_err got %h/%h exp 0", err_dir, err_to); end
    checks++; if ({err_any, first_err_ch} !== 4'd0) begin errors++; $display("FAIL reset_any got %b/%0d exp 0/0", err_any, first_err_ch); end
  endtask

  task automatic test_rising_pass();
    do_abort();
    sig_in = '0;
    do_arm(8'h01, 8'h01, 10);
    ticks(49);
    checks++; if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin errors++; $display("FAIL pass_pre busy=%b done=%b exp 1/0", busy[0], done[0]); end
    sig_in[0] = 1'b1;
    tick();
    checks++; if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin errors++; $display("FAIL pass_done done=%b busy=%b exp 1/0", done[0], busy[0]); end
    ticks(2);
    checks++; if (err_any !== 1'b0 || done[0] !== 1'b1) begin errors++; $display("FAIL pass_hold err_any=%b done=%b exp 0/1", err_any, done[0]); end
  endtask

  task automatic test_wrong_dir();
    do_abort();
    sig_in = 8'h08;
    do_arm(8'h08, 8'h08, 10);
    ticks(5);
    sig_in[3] = 1'b0;
    tick();
    checks++; if (err_dir !== 8'h08 || done[3] !== 1'b0 || err_any !== 1'b0) begin errors++; $display("FAIL dir_flag err_dir=%h done=%b any=%b exp 08/0/0", err_dir, done[3], err_any); end
    tick();
    checks++; if (err_any !== 1'b1 || first_err_ch !== 3'd3) begin errors++; $display("FAIL dir_first any=%b ch=%0d exp 1/3", err_any, first_err_ch); end
  endtask

  task automatic test_timeout();
    do_abort();
    sig_in = '0;
    do_arm(8'h02, 8'h00, 2);
    ticks(199);
    checks++; if (err_to[1] !== 1'b0 || busy[1] !== 1'b1) begin errors++; $display("FAIL to_early err_to=%b busy=%b exp 0/1", err_to[1], busy[1]); end
    tick();
    checks++; if (err_to !== 8'h02 || busy[1] !== 1'b0) begin errors++; $display("FAIL to_exact err_to=%h busy=%b exp 02/0", err_to, busy[1]); end
    do_abort();
    do_arm(8'h02, 8'h00, 0);
    ticks(10000);
    checks++; if (err_to !== '0 || err_any !== 1'b0 || busy[1] !== 1'b1) begin errors++; $display("FAIL to_zero err_to=%h any=%b busy=%b exp 00/0/1", err_to, err_any, busy[1]); end
  endtask

  task automatic test_tie();
    do_abort();
    sig_in = '0;
    do_arm(8'h24, 8'h00, 1);
    ticks(99);
    checks++; if (err_to !== '0) begin errors++; $display("FAIL tie_early err_to=%h exp 00", err_to); end
    tick();
    checks++; if (err_to !== 8'h24) begin errors++; $display("FAIL tie_both err_to=%h exp 24", err_to); end
    tick();
    checks++; if (err_any !== 1'b1 || first_err_ch !== 3'd2) begin errors++; $display("FAIL tie_first any=%b ch=%0d exp 1/2", err_any, first_err_ch); end
    do_abort();
    do_arm(8'h02, 8'h02, 1);
    ticks(99);
    sig_in[1] = 1'b1;
    tick();
    checks++; if (done[1] !== 1'b1 || err_to[1] !== 1'b0 || err_dir[1] !== 1'b0) begin errors++; $display("FAIL tie_trans done=%b err_to=%b err_dir=%b exp 1/0/0", done[1], err_to[1], err_dir[1]); end
  endtask

  task automatic test_rearm();
    do_abort();
    sig_in = '0;
    do_arm(8'h40, 8'h00, 1);
    ticks(59);
    do_arm(8'h40, 8'h00, 1);
    ticks(39);
    checks++; if (err_to[6] !== 1'b0 || busy[6] !== 1'b1) begin errors++; $display("FAIL rearm_restart err_to=%b busy=%b exp 0/1", err_to[6], busy[6]); end
    ticks(60);
    checks++; if (err_to[6] !== 1'b0) begin errors++; $display("FAIL rearm_early err_to=%b exp 0", err_to[6]); end
    tick();
    checks++; if (err_to[6] !== 1'b1) begin errors++; $display("FAIL rearm_expire err_to=%b exp 1", err_to[6]); end
    tick();
    checks++; if (err_any !== 1'b1 || first_err_ch !== 3'd6) begin errors++; $display("FAIL rearm_first any=%b ch=%0d exp 1/6", err_any, first_err_ch); end
    do_arm(8'h40, 8'h00, 1);
    checks++; if (err_to[6] !== 1'b0 || busy[6] !== 1'b1) begin errors++; $display("FAIL rearm_clear err_to=%b busy=%b exp 0/1", err_to[6], busy[6]); end
    tick();
    checks++; if (err_any !== 1'b0) begin errors++; $display("FAIL rearm_any_fall any=%b exp 0", err_any); end
  endtask

  task automatic test_abort();
    do_abort();
    sig_in = '0;
    arm = 8'h14;
    timeout_us[4*TW +: TW] = TW'(5);
    timeout_us[2*TW +: TW] = TW'(1);
    tick();
    arm = '0;
    ticks(101);
    checks++; if (err_any !== 1'b1 || first_err_ch !== 3'd2 || busy[4] !== 1'b1) begin errors++; $display("FAIL abort_pre any=%b ch=%0d busy4=%b exp 1/2/1", err_any, first_err_ch, busy[4]); end
    abort = 1'b1; arm = 8'h01; exp_rise[0] = 1'b1;
    tick();
    abort = 1'b0; arm = '0;
    checks++; if ({busy, done, err_dir, err_to} !== '0) begin errors++; $display("FAIL abort_flags busy=%h done=%h dir=%h to=%h exp 0", busy, done, err_dir, err_to); end
    checks++; if (err_any !== 1'b0 || first_err_ch !== 3'd0) begin errors++; $display("FAIL abort_any any=%b ch=%0d exp 0/0", err_any, first_err_ch); end
    sig_in[0] = 1'b1;
    ticks(3);
    checks++; if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin errors++; $display("FAIL abort_idle busy=%b done=%b exp 0/0", busy[0], done[0]); end
  endtask

  task automatic test_reset_mid();
    do_abort();
    sig_in = 8'h08;
    arm = 8'h0C; exp_rise = 8'h08;
    timeout_us[3*TW +: TW] = TW'(0);
    timeout_us[2*TW +: TW] = TW'(3);
    tick();
    arm = '0;
    ticks(5);
    sig_in[3] = 1'b0;
    ticks(3);
    checks++; if (err_any !== 1'b1 || first_err_ch !== 3'd3 || busy[2] !== 1'b1) begin errors++; $display("FAIL rstmid_pre any=%b ch=%0d busy2=%b exp 1/3/1", err_any, first_err_ch, busy[2]); end
    #2;
    tb_rst = 1'b1;
    #1;
    checks++; if ({busy, done, err_dir, err_to, err_any, first_err_ch} !== '0) begin errors++; $display("FAIL rstmid_async busy=%h dir=%h any=%b ch=%0d exp 0", busy, err_dir, err_any, first_err_ch); end
    tick();
    tb_rst = 1'b0;
    sig_in = '0;
    tick();
  endtask

  // Random rounds checked against an event-time model: each channel's outcome
  // is the earlier of its first transition and its timeout (transition on ties).
  task automatic test_random();
    for (int r = 0; r < 25; r++) begin
      logic [NCH-1:0] m, er, base, ex_done, ex_dir, ex_to, ex_busy;
      logic           ex_any;
      logic [2:0]     ex_first;
      int t[NCH];
      int d[NCH];
      int evt[NCH];
      int kind[NCH];
      int lim, best;
      do_abort();
      m    = NCH'($urandom);
      er   = NCH'($urandom);
      base = NCH'($urandom);
      sig_in = base;
      for (int i = 0; i < NCH; i++) begin
        t[i] = $urandom_range(0, 3);
        lim  = (t[i] == 0) ? 320 : t[i] * CPU + 20;
        d[i] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, lim);
        evt[i] = -1; kind[i] = 0;
        if (m[i]) begin
          if (d[i] != 0 && (t[i] == 0 || d[i] <= t[i] * CPU)) begin
            evt[i]  = d[i];
            kind[i] = ((~base[i]) == er[i]) ? 0 : 1;
          end else if (t[i] != 0) begin
            evt[i]  = t[i] * CPU;
            kind[i] = 2;
          end
        end
        exp_rise[i] = er[i];
        timeout_us[i*TW +: TW] = TW'(t[i]);
      end
      arm = m;
      tick();
      arm = '0;
      for (int n = 1; n <= 322; n++) begin
        for (int i = 0; i < NCH; i++) sig_in[i] = (d[i] != 0 && n >= d[i]) ? ~base[i] : base[i];
        tick();
        ex_done = '0; ex_dir = '0; ex_to = '0; ex_busy = '0; ex_any = 1'b0; ex_first = '0; best = -1;
        for (int i = 0; i < NCH; i++) begin
          if (m[i]) begin
            if (evt[i] >= 0 && n >= evt[i]) begin
              ex_done[i] = (kind[i] == 0);
              ex_dir[i]  = (kind[i] == 1);
              ex_to[i]   = (kind[i] == 2);
            end else begin
              ex_busy[i] = 1'b1;
            end
            if (kind[i] != 0 && evt[i] >= 0 && n >= evt[i] + 1) begin
              ex_any = 1'b1;
              if (best < 0 || evt[i] < best) begin best = evt[i]; ex_first = 3'(i); end
            end
          end
        end
        checks++; if (done !== ex_done) begin errors++; $display("FAIL rnd_done r=%0d n=%0d got %h exp %h", r, n, done, ex_done); end
        checks++; if (err_dir !== ex_dir) begin errors++; $display("FAIL rnd_dir r=%0d n=%0d got %h exp %h", r, n, err_dir, ex_dir); end
        checks++; if (err_to !== ex_to) begin errors++; $display("FAIL rnd_to r=%0d n=%0d got %h exp %h", r, n, err_to, ex_to); end
        checks++; if (busy !== ex_busy) begin errors++; $display("FAIL rnd_busy r=%0d n=%0d got %h exp %h", r, n, busy, ex_busy); end
        checks++; if (err_any !== ex_any) begin errors++; $display("FAIL rnd_any r=%0d n=%0d got %b exp %b", r, n, err_any, ex_any); end
        if (ex_any) begin
          checks++; if (first_err_ch !== ex_first) begin errors++; $display("FAIL rnd_first r=%0d n=%0d got %0d exp %0d", r, n, first_err_ch, ex_first); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rising_pass();
    test_wrong_dir();
    test_timeout();
    test_tie();
    test_rearm();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sig_edge_wdt_checker.md
Name: sig_edge_wdt_checker

Overview:
- Parametrised, synthesizable multi-channel successor to the testbench signal-transition checker and watchdog timer.
- Each of NUM_CH channels is armed with an expected edge direction and a timeout in microseconds, then watches its input for the first transition.
- Each channel reports pass, wrong-direction or timeout.
- Sits in the TB wrapper layer next to reset/power-good generation; emulation-friendly, so it contains no delays and no $fatal.

Parameters:
- NUM_CH, 8, number of monitored channels.
- TMR_W, 16, width of the per-channel timeout value in µs.
- CYC_PER_US, 100, tb_clk cycles per µs (100 MHz tb_clk).
- FILT_CYC, 4, stability filter length in cycles; used only with the optional feature.

Ports:
- tb_clk, in, 1: clock.
- tb_rst, in, 1: reset; asynchronous, active-high.
- arm, in, NUM_CH: per-channel arm pulse.
- exp_rise, in, NUM_CH: expected direction (1 = rising, 0 = falling); sampled on arm.
- timeout_us, in, NUM_CH*TMR_W: per-channel timeout, channel i at bits [i*TMR_W +: TMR_W]; sampled on arm.
- sig_in, in, NUM_CH: monitored signals, synchronous to tb_clk.
- abort, in, 1: returns all channels to IDLE and clears all flags.
- busy, out, NUM_CH: channel is ARMED.
- done, out, NUM_CH: correct transition seen; sticky.
- err_dir, out, NUM_CH: transition in the wrong direction; sticky.
- err_to, out, NUM_CH: watchdog expired; sticky.
- err_any, out, 1: registered OR of all err_dir | err_to.
- first_err_ch, out, $clog2(NUM_CH): index of the first channel to error; valid while err_any = 1.

Behaviour:
- Reset: all outputs 0, all channels IDLE, counters 0, first_err_ch = 0.
- Per-channel FSM states: IDLE, ARMED, PASS, FAIL.
  - Any state + arm[i] → ARMED. On this edge: capture exp_rise[i], timeout_us[i] and sig_in[i] (baseline); clear done/err_dir/err_to[i]; zero the cycle and µs counters.
  - Re-arming while ARMED restarts the channel.
  - ARMED + sig_in[i] != baseline:
    - new value matches expected direction → PASS, done[i] = 1.
    - otherwise → FAIL, err_dir[i] = 1.
  - ARMED + watchdog expiry → FAIL, err_to[i] = 1.
  - PASS and FAIL hold until arm[i] or abort.
- Watchdog:
  - Per-channel sub-counter counts 0..CYC_PER_US-1; on wrap it increments a TMR_W-bit µs counter.
  - Expiry when the µs counter equals the captured timeout. err_to is visible exactly timeout_us*CYC_PER_US cycles after the arm edge.
  - Captured timeout = 0 disables the watchdog; the channel waits indefinitely.
  - The µs counter does not wrap, because expiry always occurs first.
- Latency:
  - A sig_in change sampled at edge k → done/err_dir high after edge k, i.e. one register stage.
  - err_any and first_err_ch update one cycle after the err bit.
- Simultaneous events:
  - Transition and expiry in the same cycle: the transition wins.
  - abort and arm in the same cycle: abort wins; the arm is ignored.
  - Several channels erroring in the same cycle: first_err_ch takes the lowest index.
- first_err_ch:
  - Latched only when err_any transitions from 0 to 1; later errors do not change it.
  - Cleared to 0 by abort or tb_rst.
  - Re-arming the erroring channel clears its err bit; err_any falls once no err bits remain.
- abort: synchronous. All channels → IDLE; all flags, counters and first_err_ch cleared on the next edge.
- Reset mid-operation: immediate return to reset values. The in-progress check is lost and no flag is generated.

Optional Feature:
- Macro: SIG_EDGE_WDT_GLITCH_FILTER_EN.
- Defined:
  - A transition is recognised only after sig_in[i] holds the non-baseline value for FILT_CYC consecutive cycles. done/err_dir rise FILT_CYC cycles after the first differing sample.
  - A shorter pulse is ignored and the filter counter resets.
  - The watchdog keeps running during filtering.
- Undefined: behaviour as above, single-cycle recognition; FILT_CYC is unused.

Test Plan:
1. Rising pass: arm ch0 with exp_rise=1, timeout=10, sig_in[0]=0; raise sig_in[0] at cycle 50 → done[0]=1 at cycle 51; busy[0]=0; err_any stays 0.
2. Wrong direction: arm ch3 with exp_rise=1, sig_in[3]=1; drop sig_in[3] → err_dir[3]=1; err_any=1 next cycle; first_err_ch=3.
3. Timeout: arm ch1 with timeout=2 and no sig change → err_to[1]=1 exactly 200 cycles after the arm edge. Repeat with timeout=0 → no error after 10000 cycles.
4. Tie and priority: ch2 and ch5 expire in the same cycle → first_err_ch=2. Separately, ch1 transition and expiry in the same cycle → done[1]=1 and err_to[1]=0.
5. abort/reset: abort together with arm on ch0 while ch4 is ARMED → all outputs 0 next cycle and ch0 stays IDLE. Assert tb_rst mid-count → outputs 0 immediately with no clock edge.
6. Glitch filter (macro defined, FILT_CYC=4): 3-cycle pulse on armed ch0 → ignored. 4-cycle hold → done[0] rises 4 cycles after the first differing sample.
